// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per cycle, with a registered result and a single-cycle valid pulse.
package muldiv_pkg;
  localparam int data_size = 32;

  localparam logic [2:0] mul_func    = 3'b000;
  localparam logic [2:0] mulh_func   = 3'b001;
  localparam logic [2:0] mulhsu_func = 3'b010;
  localparam logic [2:0] mulhu_func  = 3'b011;
  localparam logic [2:0] div_func    = 3'b100;
  localparam logic [2:0] divu_func   = 3'b101;
  localparam logic [2:0] rem_func    = 3'b110;
  localparam logic [2:0] remu_func   = 3'b111;
endpackage

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_SIZE = data_size
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           func_i,
  input  logic [DATA_SIZE-1:0] op_a_i,
  input  logic [DATA_SIZE-1:0] op_b_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [DATA_SIZE-1:0] result_o
);

  localparam int CW = $clog2(DATA_SIZE);
  localparam int AW = 2 * DATA_SIZE;
  localparam logic [DATA_SIZE-1:0] MIN_VAL = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           func_q, func_d;
  logic [DATA_SIZE-1:0] op_a_q, op_a_d;
  logic [DATA_SIZE-1:0] op_b_q, op_b_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;
  logic [DATA_SIZE-1:0] result_q, result_d;

  logic                 is_div, signed_a, signed_b, a_neg, b_neg;
  logic                 div_zero, overflow;
  logic [DATA_SIZE-1:0] abs_a, abs_b;
  logic [DATA_SIZE:0]   add_hi;
  logic [AW-1:0]        mul_next;
  logic [DATA_SIZE:0]   rem_sh;
  logic [DATA_SIZE-1:0] diff;
  logic                 fits;
  logic [AW-1:0]        div_next;
  logic [AW-1:0]        prod;
  logic [DATA_SIZE-1:0] quot_s, rem_s;

  // Operand decode and magnitudes; op_a_q/op_b_q hold raw operands until PREP.
  always_comb begin
    is_div   = func_q[2];
    signed_a = func_q inside {mul_func, mulh_func, mulhsu_func, div_func, rem_func};
    signed_b = func_q inside {mul_func, mulh_func, div_func, rem_func};
    a_neg    = signed_a & op_a_q[DATA_SIZE-1];
    b_neg    = signed_b & op_b_q[DATA_SIZE-1];
    abs_a    = a_neg ? (~op_a_q + 1'b1) : op_a_q;
    abs_b    = b_neg ? (~op_b_q + 1'b1) : op_b_q;
    div_zero = is_div & (op_b_q == '0);
    overflow = is_div & signed_b & (op_a_q == MIN_VAL) & (op_b_q == '1);
  end

  // Multiply keeps the multiplier in the low half and shifts the product in from the top.
  always_comb begin
    add_hi   = acc_q[0] ? ({1'b0, acc_q[AW-1:DATA_SIZE]} + {1'b0, op_a_q})
                        : {1'b0, acc_q[AW-1:DATA_SIZE]};
    mul_next = {add_hi, acc_q[DATA_SIZE-1:1]};
  end

  // Divide keeps {remainder, dividend/quotient}; quotient bits enter at the bottom.
  always_comb begin
    rem_sh   = {acc_q[AW-1:DATA_SIZE], acc_q[DATA_SIZE-1]};
    fits     = rem_sh >= {1'b0, op_b_q};
    diff     = rem_sh[DATA_SIZE-1:0] - op_b_q;
    div_next = {(fits ? diff : rem_sh[DATA_SIZE-1:0]), acc_q[DATA_SIZE-2:0], fits};
  end

  always_comb begin
    prod   = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
    quot_s = (neg_a_q ^ neg_b_q) ? (~acc_q[DATA_SIZE-1:0] + 1'b1) : acc_q[DATA_SIZE-1:0];
    rem_s  = neg_a_q ? (~acc_q[AW-1:DATA_SIZE] + 1'b1) : acc_q[AW-1:DATA_SIZE];
  end

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          func_d  = func_i;
          op_a_d  = op_a_i;
          op_b_d  = op_b_i;
          state_d = PREP;
        end
      end
      PREP: begin
        neg_a_d = a_neg;
        neg_b_d = b_neg;
        cnt_d   = '0;
        op_a_d  = abs_a;
        op_b_d  = abs_b;
        acc_d   = is_div ? {{DATA_SIZE{1'b0}}, abs_a} : {{DATA_SIZE{1'b0}}, abs_b};
        if (div_zero) begin
          result_d = func_q[1] ? op_a_q : '1;
          state_d  = DONE;
        end else if (overflow) begin
          result_d = func_q[1] ? '0 : MIN_VAL;
          state_d  = DONE;
        end else begin
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d = is_div ? div_next : mul_next;
        if (cnt_q == LAST_CNT) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        case (func_q)
          mul_func:                            result_d = prod[DATA_SIZE-1:0];
          mulh_func, mulhsu_func, mulhu_func:  result_d = prod[AW-1:DATA_SIZE];
          div_func, divu_func:                 result_d = quot_s;
          default:                             result_d = rem_s;
        endcase
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a pending start and the final result write.
    if (flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      func_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit: results, latency, flush, start masking
// and asynchronous reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  func_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int testsRun = 0;
  int testsFailed = 0;

  muldiv_unit #(.DATA_SIZE(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .func_i   (func_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Starts one operation, waits for valid, then checks result, latency and the pulse ending.
  task automatic applyStimulus(input string name, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input int expLat,
                               input bit toggle);
    int n;
    @(negedge clk);
    func_i  = f;
    op_a_i  = a;
    op_b_i  = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) checkOutput({name, " busy"}, {31'b0, busy_o}, 32'd1);
      if (valid_o) break;
      if (toggle) begin
        start_i = n[0];
        func_i  = 3'(n);
        op_a_i  = $urandom;
        op_b_i  = $urandom;
      end
    end
    start_i = 1'b0;
    checkOutput({name, " result"}, result_o, exp);
    checkOutput({name, " latency"}, n, expLat);
    @(posedge clk);
    #1;
    checkOutput({name, " end"}, {30'b0, busy_o, valid_o}, 32'd0);
  endtask

  initial begin
    bit          sawValid;
    logic [31:0] prevResult;

    rst     = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    func_i  = '0;
    op_a_i  = '0;
    op_b_i  = '0;

    vecs[0]  = '{"mul_neg",      mul_func,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{"mulh_min",     mulh_func,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[2]  = '{"mulhu_max",    mulhu_func,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{"mulhsu_max",   mulhsu_func, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{"div_neg",      div_func,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{"rem_neg",      rem_func,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{"divu",         divu_func,   32'd100,      32'd7,        32'd14,       1'b0};
    vecs[7]  = '{"remu",         remu_func,   32'd100,      32'd7,        32'd2,        1'b0};
    vecs[8]  = '{"divu_zero",    divu_func,   32'h1234,     32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{"rem_zero",     rem_func,    32'h1234,     32'd0,        32'h1234,     1'b1};
    vecs[10] = '{"div_ovf",      div_func,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{"rem_ovf",      rem_func,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1};
    vecs[12] = '{"div_pos_neg",  div_func,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[13] = '{"rem_pos_neg",  rem_func,    32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};
    vecs[14] = '{"div_neg_neg",  div_func,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        1'b0};
    vecs[15] = '{"rem_neg_neg",  rem_func,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0};
    vecs[16] = '{"divu_minm1",   divu_func,   32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[17] = '{"remu_minm1",   remu_func,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[18] = '{"div_zero",     div_func,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[19] = '{"mulhu_2p16",   mulhu_func,  32'h00010000, 32'h00010000, 32'd1,        1'b0};

    #12;
    checkOutput("reset busy",   {31'b0, busy_o},  32'd0);
    checkOutput("reset valid",  {31'b0, valid_o}, 32'd0);
    checkOutput("reset result", result_o,         32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].name, vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].exp,
                    vecs[i].special ? 1 : 34, 1'b0);
    end
    prevResult = vecs[NV-1].exp;

    // Flush on the 10th CALC cycle.
    @(negedge clk);
    func_i  = mul_func;
    op_a_i  = 32'h1234;
    op_b_i  = 32'd2;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    checkOutput("flush busy", {31'b0, busy_o}, 32'd0);
    sawValid = valid_o;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_o) sawValid = 1'b1;
    end
    checkOutput("flush no valid", {31'b0, sawValid}, 32'd0);
    checkOutput("flush result held", result_o, prevResult);

    applyStimulus("mul_after_flush", mul_func, 32'd3, 32'd5, 32'd15, 34, 1'b1);

    // Asynchronous reset mid-CALC, between clock edges.
    @(negedge clk);
    func_i  = divu_func;
    op_a_i  = 32'd1000;
    op_b_i  = 32'd3;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async rst busy",   {31'b0, busy_o},  32'd0);
    checkOutput("async rst valid",  {31'b0, valid_o}, 32'd0);
    checkOutput("async rst result", result_o,         32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("divu_after_rst", divu_func, 32'd9, 32'd3, 32'd3, 34, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
